// File: rtl/arbitro_estacoes.sv
// Two-station resource arbiter: priority profiles, round-robin tie break,
// grant timeout with per-station blocking, preemption and a one-cycle pause between grants.
module arbitro_estacoes #(
  parameter int TEMPO_MAX = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] perfil0,
  input  logic [1:0] perfil1,
  input  logic       libera0,
  input  logic       libera1,
  output logic       grant0,
  output logic       grant1,
  output logic       expirou,
  output logic       LEDRGB_red,
  output logic       LEDRGB_green,
  output logic       LEDRGB_blue
);

  localparam logic [1:0]  LIVRE  = 2'd0;
  localparam logic [1:0]  CONC0  = 2'd1;
  localparam logic [1:0]  CONC1  = 2'd2;
  localparam logic [1:0]  PAUSA  = 2'd3;
  localparam logic [15:0] LIMITE = 16'(TEMPO_MAX - 1);

  logic [1:0]  estado_r;
  logic [1:0]  estado_s;
  logic [15:0] contador_r;
  logic [1:0]  perfil_ativo_r;
  logic        ultimo_r;
  logic        bloqueio0_r;
  logic        bloqueio1_r;
  logic        eleg0_s;
  logic        eleg1_s;
  logic        vence1_s;
  logic        libera_s;
  logic        timeout_s;
  logic        preempt_s;
  logic        expira_s;
  logic        bloq0_s;
  logic        bloq1_s;

  assign eleg0_s = req0 & ~bloqueio0_r;
  assign eleg1_s = req1 & ~bloqueio1_r;

  // Next-state decision: arbitration in LIVRE, exit conditions in CONCi
  always_comb begin
    estado_s  = estado_r;
    vence1_s  = 1'b0;
    libera_s  = 1'b0;
    timeout_s = 1'b0;
    preempt_s = 1'b0;
    // On a tie the station not served last wins (ultimo=0 means IE01 was last)
    if (perfil1 > perfil0) begin
      vence1_s = 1'b1;
    end else if (perfil1 == perfil0) begin
      vence1_s = ~ultimo_r;
    end else begin
      vence1_s = 1'b0;
    end
    case (estado_r)
      LIVRE: begin
        if (eleg0_s & eleg1_s) begin
          estado_s = vence1_s ? CONC1 : CONC0;
        end else if (eleg0_s) begin
          estado_s = CONC0;
        end else if (eleg1_s) begin
          estado_s = CONC1;
        end else begin
          estado_s = LIVRE;
        end
      end
      CONC0: begin
        libera_s  = libera0 | ~req0;
        timeout_s = (contador_r == LIMITE);
        preempt_s = eleg1_s & (perfil1 > perfil_ativo_r);
        estado_s  = (libera_s | timeout_s | preempt_s) ? PAUSA : CONC0;
      end
      CONC1: begin
        libera_s  = libera1 | ~req1;
        timeout_s = (contador_r == LIMITE);
        preempt_s = eleg0_s & (perfil0 > perfil_ativo_r);
        estado_s  = (libera_s | timeout_s | preempt_s) ? PAUSA : CONC1;
      end
      PAUSA: begin
        estado_s = LIVRE;
      end
      default: begin
        estado_s = LIVRE;
      end
    endcase
  end

  // Release outranks timeout, so a release in the last cycle never blocks
  always_comb begin
    expira_s = timeout_s & ~libera_s;
    if (!req0) begin
      bloq0_s = 1'b0;
    end else if (expira_s && (estado_r == CONC0)) begin
      bloq0_s = 1'b1;
    end else begin
      bloq0_s = bloqueio0_r;
    end
    if (!req1) begin
      bloq1_s = 1'b0;
    end else if (expira_s && (estado_r == CONC1)) begin
      bloq1_s = 1'b1;
    end else begin
      bloq1_s = bloqueio1_r;
    end
  end

  // State, grant bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r       <= LIVRE;
      contador_r     <= 16'd0;
      perfil_ativo_r <= 2'd0;
      ultimo_r       <= 1'b1;
      bloqueio0_r    <= 1'b0;
      bloqueio1_r    <= 1'b0;
      grant0         <= 1'b0;
      grant1         <= 1'b0;
      expirou        <= 1'b0;
      LEDRGB_red     <= 1'b0;
      LEDRGB_green   <= 1'b0;
      LEDRGB_blue    <= 1'b1;
    end else begin
      estado_r    <= estado_s;
      bloqueio0_r <= bloq0_s;
      bloqueio1_r <= bloq1_s;
      if (estado_r == LIVRE) begin
        contador_r <= 16'd0;
      end else if (((estado_r == CONC0) || (estado_r == CONC1)) && (contador_r != 16'hFFFF)) begin
        contador_r <= contador_r + 16'd1;
      end else begin
        contador_r <= contador_r;
      end
      if ((estado_r == LIVRE) && (estado_s == CONC0)) begin
        perfil_ativo_r <= perfil0;
        ultimo_r       <= 1'b0;
      end else if ((estado_r == LIVRE) && (estado_s == CONC1)) begin
        perfil_ativo_r <= perfil1;
        ultimo_r       <= 1'b1;
      end else begin
        perfil_ativo_r <= perfil_ativo_r;
        ultimo_r       <= ultimo_r;
      end
      grant0       <= (estado_s == CONC0);
      grant1       <= (estado_s == CONC1);
      expirou      <= expira_s;
      LEDRGB_red   <= bloq0_s | bloq1_s;
      LEDRGB_green <= (estado_s == CONC0) || (estado_s == CONC1);
      LEDRGB_blue  <= (estado_s == LIVRE);
    end
  end

endmodule

// File: tb/tb_arbitro_estacoes.sv
// Scoreboard bench for arbitro_estacoes: directed scenarios then random traffic,
// expected outputs from a grant-ownership model queued per clock edge.
module tb_arbitro_estacoes;

  localparam int TM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [1:0] perfil0 = 2'd0;
  logic [1:0] perfil1 = 2'd0;
  logic       libera0 = 1'b0;
  logic       libera1 = 1'b0;
  logic       grant0, grant1, expirou, LEDRGB_red, LEDRGB_green, LEDRGB_blue;

  arbitro_estacoes #(.TEMPO_MAX(TM)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .perfil0(perfil0), .perfil1(perfil1), .libera0(libera0), .libera1(libera1),
    .grant0(grant0), .grant1(grant1), .expirou(expirou),
    .LEDRGB_red(LEDRGB_red), .LEDRGB_green(LEDRGB_green), .LEDRGB_blue(LEDRGB_blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [5:0] v;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: who owns the resource, for how many cycles, plus blocks
  int owner = -1;
  int elapsed = 0;
  bit pause = 1'b0;
  bit blk[2] = '{1'b0, 1'b0};
  int last = 1;
  int pa = 0;

  task automatic model(input bit r, input bit q0, input bit q1, input int f0, input int f1,
                       input bit l0, input bit l1, output logic [5:0] v);
    bit q[2];
    int f[2];
    bit l[2];
    bit el[2];
    bit nb[2];
    bit ex;
    int o;
    int w;
    q = '{q0, q1}; f = '{f0, f1}; l = '{l0, l1};
    ex = 1'b0;
    if (r) begin
      owner = -1; pause = 1'b0; blk = '{1'b0, 1'b0}; last = 1; pa = 0; elapsed = 0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        el[j] = q[j] && !blk[j];
        nb[j] = q[j] ? blk[j] : 1'b0;
      end
      if (owner >= 0) begin
        o = owner;
        if (l[o] || !q[o]) begin
          owner = -1; pause = 1'b1;
        end else if (elapsed == TM) begin
          owner = -1; pause = 1'b1; ex = 1'b1; nb[o] = 1'b1;
        end else if (el[1-o] && (f[1-o] > pa)) begin
          owner = -1; pause = 1'b1;
        end else begin
          elapsed++;
        end
      end else if (pause) begin
        pause = 1'b0;
      end else begin
        w = -1;
        if (el[0] && el[1]) w = (f[0] > f[1]) ? 0 : ((f[1] > f[0]) ? 1 : 1 - last);
        else if (el[0]) w = 0;
        else if (el[1]) w = 1;
        if (w >= 0) begin
          owner = w; elapsed = 1; pa = f[w]; last = w;
        end
      end
      blk = nb;
    end
    v = {owner == 0, owner == 1, ex, blk[0] | blk[1], owner >= 0, (owner < 0) && !pause};
  endtask

  task automatic step(input bit r, input bit q0, input bit q1, input int f0, input int f1,
                      input bit l0, input bit l1);
    exp_t e;
    logic [5:0] v;
    @(posedge clk);
    #1;
    rst = r; req0 = q0; req1 = q1; perfil0 = 2'(f0); perfil1 = 2'(f1);
    libera0 = l0; libera1 = l1;
    model(r, q0, q1, f0, f1, l0, l1, v);
    e.edge_n = edge_cnt + 1;
    e.v = v;
    sb.push_back(e);
  endtask

  // Monitor: invariants every cycle, scoreboard pop when the edge matches
  int run = 0;
  initial begin
    exp_t e;
    logic [5:0] got;
    forever begin
      @(negedge clk);
      checks++;
      if (!(grant0 === 1'b1 && grant1 === 1'b1)) passed++;
      else $display("FAIL mutex edge %0d: grant0=%b grant1=%b, required not both high", edge_cnt, grant0, grant1);
      if (grant0 === 1'b1 || grant1 === 1'b1) run++;
      else run = 0;
      if (run > 0) begin
        checks++;
        if (run <= TM) passed++;
        else $display("FAIL grant_len edge %0d: length %0d, required <= %0d", edge_cnt, run, TM);
      end
      while (sb.size() > 0 && sb[0].edge_n < edge_cnt) begin
        e = sb.pop_front();
        checks++;
        $display("FAIL stale edge %0d: expectation never compared, required %b", e.edge_n, e.v);
      end
      if (sb.size() > 0 && sb[0].edge_n == edge_cnt) begin
        e = sb.pop_front();
        got = {grant0, grant1, expirou, LEDRGB_red, LEDRGB_green, LEDRGB_blue};
        checks++;
        if (got === e.v) passed++;
        else $display("FAIL outputs edge %0d: got %b required %b (g0 g1 exp red green blue)", edge_cnt, got, e.v);
      end
    end
  end

  initial begin
    bit r0, r1;
    int f0, f1;
    // Reset and single request with voluntary release
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0, 0);
    // Tie at equal profile, round robin
    repeat (3) step(0, 1, 1, 2, 2, 0, 0);
    step(0, 1, 1, 2, 2, 1, 0);
    repeat (3) step(0, 1, 1, 2, 2, 0, 0);
    step(0, 1, 1, 2, 2, 0, 1);
    repeat (3) step(0, 1, 1, 2, 2, 0, 0);
    repeat (3) step(0, 0, 0, 2, 2, 0, 0);
    // Timeout, block until the request drops
    repeat (10) step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    // Preemption by strictly higher profile, and none at equal profile
    repeat (2) step(0, 1, 0, 1, 0, 0, 0);
    repeat (5) step(0, 1, 1, 1, 3, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 1, 1, 0, 0);
    repeat (2) step(0, 1, 1, 1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    // Release in the timeout cycle, then reset mid-grant
    repeat (4) step(0, 1, 0, 2, 0, 0, 0);
    step(0, 1, 0, 2, 0, 1, 0);
    repeat (4) step(0, 1, 0, 2, 0, 0, 0);
    step(1, 1, 0, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Random traffic
    r0 = 0; r1 = 0; f0 = 0; f1 = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom % 8 == 0) r0 = ~r0;
      if ($urandom % 8 == 0) r1 = ~r1;
      if ($urandom % 6 == 0) f0 = int'($urandom % 4);
      if ($urandom % 6 == 0) f1 = int'($urandom % 4);
      step(($urandom % 300) == 0, r0, r1, f0, f1, ($urandom % 10) == 0, ($urandom % 10) == 0);
    end
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, required 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
